// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI controller FSM encoding, port indices and default timing
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_READY = 3'd3;
  localparam logic [2:0] ST_LOAD  = 3'd4;
  localparam logic [2:0] ST_SHIFT = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_HOLD  = 3'd7;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DIV_DEF      = 4;
  localparam int CS_SETUP_DEF = 2;
  localparam int CS_HOLD_DEF  = 2;

  // Round-robin winner: on contention the port not granted last time wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// rtl/spi_xfer_ctrl_if.sv - requester-side bus of the two-port SPI transaction controller
interface spi_xfer_ctrl_if;
  logic [1:0] req_cs;
  logic [1:0] req_wr;
  logic [7:0] req_d0;
  logic [7:0] req_d1;
  logic [1:0] grant;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       busy;
  logic       timeout;

  modport master (
    output req_cs, req_wr, req_d0, req_d1,
    input  grant, ack, rdata, busy, timeout
  );

  modport slave (
    input  req_cs, req_wr, req_d0, req_d1,
    output grant, ack, rdata, busy, timeout
  );
endinterface

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SPI shift-clock divider with a one-clock falling-edge strobe
module spi_clk_div (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_enable,
  input  logic [7:0] i_tc,
  output logic       o_sh_clk,
  output logic       o_fall_stb
);
  logic [7:0] r_cnt;
  logic       r_sh_clk;
  logic       r_fall_stb;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= 8'd0;
      r_sh_clk   <= 1'b0;
      r_fall_stb <= 1'b0;
    end else if (!i_enable) begin
      r_cnt      <= 8'd0;
      r_sh_clk   <= 1'b0;
      r_fall_stb <= 1'b0;
    end else if (r_cnt == i_tc) begin
      r_cnt      <= 8'd0;
      r_sh_clk   <= ~r_sh_clk;
      r_fall_stb <= r_sh_clk;
    end else begin
      r_cnt      <= r_cnt + 8'd1;
      r_fall_stb <= 1'b0;
    end
  end

  assign o_sh_clk   = r_sh_clk;
  assign o_fall_stb = r_fall_stb;
endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - two-port SPI transaction controller: arbitration, CS timing, byte sequencing
// Optional idle-ownership timeout is built when SPI_XFER_TIMEOUT_EN is defined.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DIV      = DIV_DEF,
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_HOLD  = CS_HOLD_DEF,
  parameter int TIMEOUT  = 65535
) (
  input  logic           clock,
  input  logic           reset,
  spi_xfer_ctrl_if.slave bus,
  output logic           sh_clk,
  output logic           sh_load,
  output logic [7:0]     sh_d,
  input  logic [7:0]     sh_q,
  output logic           spi_cs_n
);
  localparam logic [7:0]  DIV_TC   = 8'(DIV - 1);
  localparam logic [7:0]  SETUP_TC = 8'(CS_SETUP - 1);
  localparam logic [7:0]  HOLD_TC  = 8'(CS_HOLD - 1);
  localparam logic [15:0] TO_TC    = 16'(TIMEOUT - 1);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_bit;
  logic       r_owner;
  logic       r_last;
  logic [1:0] r_grant;
  logic [1:0] r_ack;
  logic [7:0] r_rdata;
  logic [7:0] r_sh_d;
  logic       r_load;
  logic       r_cs_n;
  logic [1:0] w_req;
  logic       w_pick;
  logic       w_wr;
  logic       w_fall_stb;
  logic       w_div_en;
  logic       w_to_hit;

  assign w_div_en = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
  assign w_wr     = bus.req_wr[r_owner];
  assign w_pick   = rr_pick(w_req, r_last);

  spi_clk_div u_clk_div (
    .clock      (clock),
    .reset      (reset),
    .i_enable   (w_div_en),
    .i_tc       (DIV_TC),
    .o_sh_clk   (sh_clk),
    .o_fall_stb (w_fall_stb)
  );

`ifdef SPI_XFER_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic [1:0]  r_block;
  logic        r_timeout;

  // A timed-out port stays masked from arbitration until it drops req_cs.
  assign w_req    = bus.req_cs & ~r_block;
  assign w_to_hit = (r_state == ST_READY) && (r_to_cnt == TO_TC) && !w_wr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_to_cnt  <= 16'd0;
      r_block   <= 2'b00;
      r_timeout <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == ST_READY) ? r_to_cnt + 16'd1 : 16'd0;
      if (w_to_hit) begin
        r_timeout <= 1'b1;
        r_block   <= (r_block | r_grant) & bus.req_cs;
      end else begin
        r_block   <= r_block & bus.req_cs;
      end
    end
  end

  assign bus.timeout = r_timeout;
`else
  logic w_unused_to;

  assign w_req       = bus.req_cs;
  assign w_to_hit    = 1'b0;
  assign w_unused_to = |TO_TC;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_bit   <= 3'd0;
      r_owner <= PORT0;
      r_last  <= PORT1;
      r_grant <= 2'b00;
      r_ack   <= 2'b00;
      r_rdata <= 8'd0;
      r_sh_d  <= 8'd0;
      r_load  <= 1'b0;
      r_cs_n  <= 1'b1;
    end else begin
      r_ack <= 2'b00;
      case (r_state)
        ST_IDLE: if (|w_req) r_state <= ST_ARB;
        ST_ARB: begin
          if (|w_req) begin
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_grant <= (w_pick == PORT1) ? 2'b10 : 2'b01;
            r_cs_n  <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= ST_SETUP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (r_cnt == SETUP_TC) begin
            r_cnt   <= 8'd0;
            r_state <= ST_READY;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // A write in the same clock as the owner's release still goes out.
        ST_READY: begin
          if (w_wr) begin
            r_sh_d  <= r_owner ? bus.req_d1 : bus.req_d0;
            r_load  <= 1'b1;
            r_state <= ST_LOAD;
          end else if (!bus.req_cs[r_owner] || w_to_hit) begin
            r_cnt   <= 8'd0;
            r_state <= ST_HOLD;
          end
        end
        ST_LOAD: begin
          if (w_fall_stb) begin
            r_load  <= 1'b0;
            r_bit   <= 3'd0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_fall_stb) begin
            if (r_bit == 3'd7) r_state <= ST_DONE;
            else               r_bit   <= r_bit + 3'd1;
          end
        end
        ST_DONE: begin
          r_rdata <= sh_q;
          r_ack   <= r_grant;
          r_state <= ST_READY;
        end
        ST_HOLD: begin
          if (r_cnt == HOLD_TC) begin
            r_cnt   <= 8'd0;
            r_cs_n  <= 1'b1;
            r_grant <= 2'b00;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant = r_grant;
  assign bus.ack   = r_ack;
  assign bus.rdata = r_rdata;
  assign bus.busy  = (r_state != ST_IDLE) && (r_state != ST_READY);
  assign sh_load   = r_load;
  assign sh_d      = r_sh_d;
  assign spi_cs_n  = r_cs_n;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - directed bench for spi_xfer_ctrl with a looped-back shifter model
module tb_spi_xfer_ctrl;
  localparam int DIV = 2;
  localparam int LAT = 2 + 18 * DIV;

  logic       clock;
  logic       reset;
  logic       sh_clk;
  logic       sh_load;
  logic [7:0] sh_d;
  logic [7:0] sh_q_m;
  logic       spi_cs_n;

  spi_xfer_ctrl_if bus ();

  spi_xfer_ctrl #(.DIV(DIV), .CS_SETUP(2), .CS_HOLD(2), .TIMEOUT(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .sh_clk   (sh_clk),
    .sh_load  (sh_load),
    .sh_d     (sh_d),
    .sh_q     (sh_q_m),
    .spi_cs_n (spi_cs_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int sck_cnt = 0;
  int fall_cnt = 0;
  logic sck_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Shifter model with MISO tied to MOSI: loads on sh_load, rotates left on each sh_clk rise.
  always @(negedge clock) begin
    if (sh_clk && !sck_prev && !sh_load) sck_cnt <= sck_cnt + 1;
    if (!sh_clk && sck_prev) fall_cnt <= fall_cnt + 1;
    if (sh_load) sh_q_m <= sh_d;
    else if (sh_clk && !sck_prev) sh_q_m <= {sh_q_m[6:0], sh_q_m[7]};
    sck_prev <= sh_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_cs = 2'b00;
    bus.req_wr = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic acquire(input int p);
    int n = 0;
    bus.req_cs[p] = 1'b1;
    do begin
      tick();
      n++;
    end while (!(bus.grant[p] && !bus.busy) && n < 200);
  endtask

  task automatic release_bus(input int p);
    int n = 0;
    bus.req_cs[p] = 1'b0;
    while ((bus.grant != 2'b00 || !spi_cs_n) && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_ack(input int t0, output int lat, output logic cs_bad);
    cs_bad = 1'b0;
    while (bus.ack == 2'b00 && (cyc - t0) < 500) begin
      tick();
      if (spi_cs_n) cs_bad = 1'b1;
    end
    lat = cyc - t0;
  endtask

  task automatic xfer(input int p, input logic [7:0] d, output int lat, output int sck, output logic cs_bad);
    int s0, t0;
    if (p == 0) bus.req_d0 = d;
    else        bus.req_d1 = d;
    s0 = sck_cnt;
    bus.req_wr[p] = 1'b1;
    tick();
    bus.req_wr = 2'b00;
    t0 = cyc;
    wait_ack(t0, lat, cs_bad);
    sck = sck_cnt - s0;
  endtask

  task automatic handoff(input int from, input logic [1:0] exp_grant);
    int n = 0;
    int c;
    bus.req_cs[from] = 1'b0;
    while (bus.grant != 2'b00 && n < 200) begin tick(); n++; end
    c = cyc;
    while (bus.grant == 2'b00 && n < 200) begin tick(); n++; end
    check("handoff_grant", bus.grant, exp_grant);
    check("regrant_gap", cyc - c, 2);
    while (bus.busy && n < 200) begin tick(); n++; end
    bus.req_cs[from] = 1'b1;
  endtask

  typedef struct {
    int         port;
    logic [7:0] d;
    logic [1:0] exp_grant;
    logic [7:0] exp_rdata;
    int         exp_lat;
    int         exp_sck;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, sck, n, t0, f0;
    logic cs_bad;
    logic [1:0] ack_acc;

    vecs[0] = '{0, 8'hA5, 2'b01, 8'hA5, 38, 8};
    vecs[1] = '{1, 8'h3C, 2'b10, 8'h3C, 38, 8};
    vecs[2] = '{0, 8'hFF, 2'b01, 8'hFF, 38, 8};
    vecs[3] = '{1, 8'h00, 2'b10, 8'h00, 38, 8};
    vecs[4] = '{0, 8'h81, 2'b01, 8'h81, 38, 8};

    reset = 1'b1;
    bus.req_cs = 2'b00;
    bus.req_wr = 2'b00;
    bus.req_d0 = 8'h00;
    bus.req_d1 = 8'h00;
    tick();
    tick();
    check("rst_grant", bus.grant, 2'b00);
    check("rst_ack", bus.ack, 2'b00);
    check("rst_rdata", bus.rdata, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_timeout", bus.timeout, 1'b0);
    check("rst_sh_clk", sh_clk, 1'b0);
    check("rst_sh_load", sh_load, 1'b0);
    check("rst_sh_d", sh_d, 8'h00);
    check("rst_cs_n", spi_cs_n, 1'b1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      acquire(vecs[i].port);
      check("vec_grant", bus.grant, vecs[i].exp_grant);
      check("vec_cs_low", spi_cs_n, 1'b0);
      xfer(vecs[i].port, vecs[i].d, lat, sck, cs_bad);
      check("vec_ack", bus.ack, vecs[i].exp_grant);
      check("vec_rdata", bus.rdata, vecs[i].exp_rdata);
      check("vec_latency", lat, vecs[i].exp_lat);
      check("vec_sck", sck, vecs[i].exp_sck);
      check("vec_cs_held", cs_bad, 1'b0);
      release_bus(vecs[i].port);
      check("vec_released", {bus.grant, spi_cs_n}, 3'b001);
    end

    // Ignored writes: non-owner strobe, then owner strobe while busy.
    acquire(0);
    bus.req_d1 = 8'h55;
    bus.req_wr[1] = 1'b1;
    tick();
    bus.req_wr = 2'b00;
    check("ign_load", sh_load, 1'b0);
    check("ign_sh_d", sh_d, vecs[4].d);
    check("ign_busy", bus.busy, 1'b0);
    ack_acc = 2'b00;
    for (int i = 0; i < 3; i++) begin tick(); ack_acc |= bus.ack; end
    check("ign_no_ack", ack_acc, 2'b00);
    bus.req_d0 = 8'h96;
    bus.req_wr[0] = 1'b1;
    tick();
    bus.req_wr = 2'b00;
    t0 = cyc;
    tick(); tick(); tick();
    bus.req_d0 = 8'h11;
    bus.req_wr[0] = 1'b1;
    tick();
    bus.req_wr = 2'b00;
    check("busy_wr_sh_d", sh_d, 8'h96);
    wait_ack(t0, lat, cs_bad);
    check("busy_wr_latency", lat, LAT);
    check("busy_wr_rdata", bus.rdata, 8'h96);
    ack_acc = 2'b00;
    n = 0;
    for (int i = 0; i < 6; i++) begin tick(); ack_acc |= bus.ack; n += int'(sh_load); end
    check("busy_wr_no_queue_ack", ack_acc, 2'b00);
    check("busy_wr_no_queue_load", n, 0);
    release_bus(0);

    // Release in the same clock as the write.
    acquire(0);
    bus.req_d0 = 8'h5A;
    bus.req_wr[0] = 1'b1;
    bus.req_cs[0] = 1'b0;
    tick();
    bus.req_wr = 2'b00;
    t0 = cyc;
    wait_ack(t0, lat, cs_bad);
    check("rel_wr_ack", bus.ack, 2'b01);
    check("rel_wr_latency", lat, LAT);
    check("rel_wr_rdata", bus.rdata, 8'h5A);
    t0 = cyc;
    n = 0;
    while (!spi_cs_n && n < 100) begin tick(); n++; end
    check("rel_wr_hold", cyc - t0, 3);
    check("rel_wr_grant", bus.grant, 2'b00);

    // Contention straight after reset: port 0 first, then alternating.
    do_reset();
    bus.req_cs = 2'b11;
    n = 0;
    while (bus.grant == 2'b00 && n < 100) begin tick(); n++; end
    check("cont_first", bus.grant, 2'b01);
    while (bus.busy && n < 100) begin tick(); n++; end
    handoff(0, 2'b10);
    handoff(1, 2'b01);
    handoff(0, 2'b10);
    bus.req_cs = 2'b00;
    release_bus(1);

    // Asynchronous reset in the middle of a byte.
    acquire(0);
    bus.req_d0 = 8'h3C;
    bus.req_wr[0] = 1'b1;
    tick();
    bus.req_wr = 2'b00;
    f0 = fall_cnt;
    n = 0;
    while ((fall_cnt - f0) < 4 && n < 200) begin tick(); n++; end
    check("mid_in_shift", bus.busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_cs_n", spi_cs_n, 1'b1);
    check("mid_rst_grant", bus.grant, 2'b00);
    check("mid_rst_sh_clk", sh_clk, 1'b0);
    check("mid_rst_ack", bus.ack, 2'b00);
    bus.req_cs = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    ack_acc = 2'b00;
    for (int i = 0; i < 10; i++) begin tick(); ack_acc |= bus.ack; end
    check("mid_rst_no_ack", ack_acc, 2'b00);
    acquire(0);
    xfer(0, 8'hC3, lat, sck, cs_bad);
    check("mid_next_rdata", bus.rdata, 8'hC3);
    check("mid_next_latency", lat, LAT);
    check("mid_next_sck", sck, 8);
    release_bus(0);

`ifdef SPI_XFER_TIMEOUT_EN
    // Owner idles in READY while port 1 waits.
    acquire(0);
    bus.req_cs[1] = 1'b1;
    t0 = cyc;
    n = 0;
    while (!bus.busy && n < 100) begin tick(); n++; end
    check("to_release_time", cyc - t0, 16);
    check("to_flag", bus.timeout, 1'b1);
    n = 0;
    while (!(bus.grant != 2'b00 && !bus.busy) && n < 100) begin tick(); n++; end
    check("to_pass_grant", bus.grant, 2'b10);
    release_bus(1);
    ack_acc = 2'b00;
    for (int i = 0; i < 6; i++) begin tick(); ack_acc |= bus.grant; end
    check("to_owner_blocked", ack_acc, 2'b00);
    bus.req_cs[0] = 1'b0;
    tick();
    acquire(0);
    check("to_rerequest", bus.grant, 2'b01);
    check("to_sticky", bus.timeout, 1'b1);
    release_bus(0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
